// File: rtl/risc_pkg.sv
// Shared definitions for the 8-phase RISC CPU: run-control state encodings and phase names
// used by both the sequencer and the instruction-decode controller.
package risc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    HALTED = 2'b11
  } run_state_e;

  localparam int         NUM_PHASES = 8;
  localparam logic [2:0] PH_HALT    = 3'd4;
  localparam logic [2:0] PH_LAST    = 3'(NUM_PHASES - 1);

endpackage

// File: rtl/cpu_sequencer.sv
// Run-control sequencer: owns the CPU phase counter, gates datapath updates via cpu_en,
// and arbitrates free-run, single-step and halt/clear-halt requests.
module cpu_sequencer
  import risc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step_req,
  input  logic             clr_halt,
  input  logic             halt,
  output logic [2:0]       phase,
  output logic             cpu_en,
  output logic             instr_done,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  // Request semantics: run is a level sampled in IDLE and at the phase-7 cycle of RUN;
  // step_req and clr_halt are one-cycle pulses acted on only in IDLE / HALTED respectively
  // and never queued; halt is sampled only in the phase-4 cycle of RUN or STEP.

  run_state_e       state_q, state_n;
  logic [2:0]       phase_q, phase_n;
  logic [CNT_W-1:0] cnt_q;
  logic             halted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      phase_q  <= phase_n;
      halted_q <= (state_n == HALTED);
    end
  end

  always_comb begin
    state_n = state_q;
    phase_n = phase_q;
    case (state_q)
      IDLE: begin
        phase_n = '0;
        if (run)           state_n = RUN;
        else if (step_req) state_n = STEP;
      end
      RUN, STEP: begin
        // Halt wins over the instruction boundary and any run change.
        if ((phase_q == PH_HALT) && halt) begin
          state_n = HALTED;
          phase_n = '0;
        end else if (phase_q == PH_LAST) begin
          phase_n = '0;
          if ((state_q == STEP) || !run) state_n = IDLE;
        end else begin
          phase_n = phase_q + 3'd1;
        end
      end
      HALTED: begin
        phase_n = '0;
        if (clr_halt) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        phase_n = '0;
      end
    endcase
  end

  assign cpu_en     = (state_q == RUN) || (state_q == STEP);
  assign instr_done = cpu_en && (phase_q == PH_LAST);

  // Retired-instruction counter saturates rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (instr_done && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign phase     = phase_q;
  assign state     = state_q;
  assign halted    = halted_q;
  assign instr_cnt = cnt_q;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Run-control sequencer for the 8-phase RISC CPU. It generates the 3-bit `phase` that drives the instruction-decode controller and gates datapath register updates through `cpu_en`. It accepts free-run, single-step and halt-clear requests from the debug/host side and reacts to the controller's `halt`. It sits between the host interface and the controller, and is the only source of `phase` in the CPU.

## Interface
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` in 1: single system clock, rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: level; 1 requests continuous execution.
- `step_req` in 1: single-cycle pulse; requests execution of exactly one instruction.
- `clr_halt` in 1: single-cycle pulse; releases the HALTED state.
- `halt` in 1: from the controller; meaningful only in phase 4.
- `phase` out 3: current instruction phase, 0..7, registered.
- `cpu_en` out 1: enable for PC, IR and AC register updates.
- `instr_done` out 1: high during the phase-7 cycle of an executing instruction.
- `halted` out 1: high in HALTED.
- `state` out 2: IDLE=00, RUN=01, STEP=10, HALTED=11.
- `instr_cnt` out CNT_W: count of retired instructions; saturates at all-ones.

## Operation
- **IDLE**
  - `phase`=0, `cpu_en`=0.
  - If `run`=1: go to RUN.
  - Else if `step_req`=1: go to STEP.
  - `run` has priority when both are high.
- **RUN**
  - `phase` increments every cycle and wraps 7→0.
  - `run` is sampled only at the phase-7 cycle. If `run`=0 there: go to IDLE with `phase`=0. Otherwise continue with phase 0.
  - Stop requests are therefore honoured only at instruction boundaries.
- **STEP**
  - Executes phases 0..7 once, then goes to IDLE.
  - `run` and `step_req` are ignored during STEP.
- **Halt**
  - In RUN or STEP, the cycle with `phase`=4 and `halt`=1 moves the next state to HALTED with `phase`=0.
  - `cpu_en` stays 1 during that phase-4 cycle, so the controller's `inc_pc` still takes effect.
  - The halted instruction does not retire: no `instr_done` pulse, no count increment.
  - `halt` is ignored in all other phases and states.
- **HALTED**
  - `phase`=0, `cpu_en`=0, `halted`=1.
  - Only `clr_halt`=1 exits, to IDLE.
  - `run` and `step_req` are ignored. A `run` still high after `clr_halt` re-enters RUN one cycle later.
- **Ignored requests**
  - `clr_halt` outside HALTED is ignored.
  - `step_req` in RUN is ignored and not queued.
- **Output decode**
  - `cpu_en` = state is RUN or STEP.
  - `instr_done` = `cpu_en` & (`phase`==7).
- **Counter**
  - `instr_cnt` increments on each edge where `instr_done`=1.
  - At all-ones it holds.
  - It is cleared only by `rst`.

## Timing
- **Reset**
  - `rst` asserted forces IDLE immediately.
  - All outputs reset to 0: `phase`, `cpu_en`, `instr_done`, `halted`, `state`, `instr_cnt`.
  - Reset mid-instruction abandons the instruction with no retirement.
- **Start latency**
  - Request sampled at edge k.
  - Cycle k+1: `phase`=0, `cpu_en`=1.
- **Instruction length**
  - Exactly 8 enabled cycles.
  - Back-to-back instructions in RUN have no bubble.
- **STEP length**
  - 8 cycles with `cpu_en`=1, then IDLE on the following cycle.
- **Halt latency**
  - `halt` seen in the phase-4 cycle; `halted`=1 from the next cycle.
- **Simultaneous events**
  - `halt` in phase 4 takes precedence over any `run` change.
  - At phase 7, a `run` drop and the instruction retirement both take effect: count increments and state goes to IDLE.

## Structure
- Shared package `risc_pkg` holds:
  - the state encodings (IDLE, RUN, STEP, HALTED);
  - `NUM_PHASES`=8;
  - the phase names: PH_HALT=4 and PH_LAST=7.
- The controller also uses the phase names from this package.
- Single module; the phase counter and state register are inline, with no sub-module.
- The FSM is a registered state plus combinational next-state logic. All outputs except `instr_done` and `cpu_en` are registered.

## Test plan
- **Reset:** assert `rst` mid-RUN at `phase`=3 → `state`=00, `phase`=0, `cpu_en`=0, `instr_cnt`=0 immediately.
- **Free run:** `run`=1 for 20 cycles, `halt`=0 → phase sequence 0..7,0..7,0..3. Drop `run` → completes through phase 7, then IDLE, `instr_cnt`=3.
- **Single step:** `step_req` pulse from IDLE → 8 cycles of `cpu_en`=1 with phases 0..7, then IDLE, `instr_cnt`=1. A second `step_req` during STEP is ignored, so the count stays 1.
- **Halt:** RUN with `halt`=1 at phase 4 of the 2nd instruction → `cpu_en`=1 in that cycle, next cycle `halted`=1, `phase`=0, `instr_cnt`=1. `run`/`step_req` pulses are then ignored.
- **Clear halt:** `clr_halt` pulse in HALTED with `run`=1 → IDLE for one cycle, then RUN with `phase`=0. `clr_halt` in IDLE causes no change.
- **Saturation:** `CNT_W`=2, free-run 5 instructions → `instr_cnt` sequence 1,2,3,3,3.
